// File: rtl/ram_program_loader_if.sv
// Loader-side bundle: incoming byte stream plus main-bus drive and RAM strobes.
// master = loader, slave = byte source / bus-and-RAM side.
interface ram_program_loader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] bus_out;
    logic                  bus_oe;
    logic                  MI;
    logic                  RI;
    logic                  ram_clk;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output bus_out,
        output bus_oe,
        output MI,
        output RI,
        output ram_clk
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  bus_out,
        input  bus_oe,
        input  MI,
        input  RI,
        input  ram_clk
    );
endinterface

// File: rtl/ram_program_loader.sv
// Program-RAM loader: writes 2^ADDR_WIDTH streamed bytes to addresses 0..DEPTH-1 while the CPU is held.
// Latency: 6 clk per byte from acceptance back to WAIT_BYTE (address phase 3 clk, data phase 3 clk).
// Backpressure: rx_ready only in WAIT_BYTE; a byte offered during a write is dropped and flags overrun.
module ram_program_loader #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    ram_program_loader_if.master  lif,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  overrun,
    output logic [ADDR_WIDTH:0]   byte_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]         TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_A_SETUP,
        S_A_PULSE,
        S_A_HOLD,
        S_D_SETUP,
        S_D_PULSE,
        S_D_HOLD,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic                    start_q;
    logic                    start_edge;
    logic                    can_start;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [TW-1:0]           timer;

    assign start_edge = start & ~start_q;
    assign can_start  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_edge) begin
                    state_nx = S_WAIT_BYTE;
                end
            end
            S_WAIT_BYTE: begin
                // An arriving byte wins over a timeout landing in the same cycle.
                if (lif.rx_valid) begin
                    state_nx = S_A_SETUP;
                end else if (timer == TIMER_LAST) begin
                    state_nx = S_ERROR;
                end
            end
            S_A_SETUP: state_nx = S_A_PULSE;
            S_A_PULSE: state_nx = S_A_HOLD;
            S_A_HOLD:  state_nx = S_D_SETUP;
            S_D_SETUP: state_nx = S_D_PULSE;
            S_D_PULSE: state_nx = S_D_HOLD;
            S_D_HOLD: begin
                if (addr == ADDR_LAST) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_WAIT_BYTE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decode from state only, so the async reset drops every strobe at once.
    always_comb begin
        lif.rx_ready = 1'b0;
        lif.bus_out  = '0;
        lif.bus_oe   = 1'b0;
        lif.MI       = 1'b0;
        lif.RI       = 1'b0;
        lif.ram_clk  = 1'b0;
        busy         = 1'b0;
        cpu_hold     = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (state)
            S_WAIT_BYTE: begin
                lif.rx_ready = 1'b1;
                busy         = 1'b1;
                cpu_hold     = 1'b1;
            end
            S_A_SETUP, S_A_PULSE, S_A_HOLD: begin
                busy         = 1'b1;
                cpu_hold     = 1'b1;
                lif.bus_oe   = 1'b1;
                lif.bus_out  = DATA_WIDTH'(addr);
                lif.MI       = 1'b1;
                lif.ram_clk  = (state == S_A_PULSE);
            end
            S_D_SETUP, S_D_PULSE, S_D_HOLD: begin
                busy         = 1'b1;
                cpu_hold     = 1'b1;
                lif.bus_oe   = 1'b1;
                lif.bus_out  = data_q;
                lif.RI       = 1'b1;
                lif.ram_clk  = (state == S_D_PULSE);
            end
            S_DONE: begin
                done         = 1'b1;
            end
            S_ERROR: begin
                // Partial image must never run, so the CPU stays halted.
                err          = 1'b1;
                cpu_hold     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath: address, byte latch, timeout timer, counters and overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b0;
            addr       <= '0;
            data_q     <= '0;
            timer      <= '0;
            byte_count <= '0;
            overrun    <= 1'b0;
        end else begin
            start_q <= start;
            if (can_start && start_edge) begin
                addr       <= '0;
                timer      <= '0;
                byte_count <= '0;
                overrun    <= 1'b0;
            end else begin
                if (state == S_WAIT_BYTE && !lif.rx_valid) begin
                    timer <= timer + TW'(1);
                end else begin
                    timer <= '0;
                end
                if (state == S_WAIT_BYTE && lif.rx_valid) begin
                    data_q <= lif.rx_data;
                end
                if (state == S_D_HOLD) begin
                    byte_count <= byte_count + (ADDR_WIDTH + 1)'(1);
                    if (addr != ADDR_LAST) begin
                        addr <= addr + ADDR_WIDTH'(1);
                    end
                end
                if (busy && !lif.rx_ready && lif.rx_valid) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_program_loader.sv
// Bench for ram_program_loader: table-driven write sequence plus randomized loads against a RAM model.
module tb_ram_program_loader;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int TO    = 50;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cpu_hold, busy, done, err, overrun;
    logic [AW:0]   byte_count;

    ram_program_loader_if #(.DATA_WIDTH(DW)) lif ();

    ram_program_loader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lif(lif),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
        .overrun(overrun), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // External RAM + MAR: MAR latches on ram_clk with MI, RAM writes on ram_clk with RI.
    logic [DW-1:0] ram [DEPTH];
    logic [AW-1:0] mar = '0;
    int mi_cnt = 0, ri_cnt = 0, both_cnt = 0;
    always @(posedge lif.ram_clk) begin
        if (lif.MI) begin mar = lif.bus_out[AW-1:0]; mi_cnt++; end
        if (lif.RI) begin ram[mar] = lif.bus_out; ri_cnt++; end
    end
    always @(negedge clk) if (lif.MI && lif.RI) both_cnt++;

    int n_chk = 0, n_fail = 0;
    int mi_base = 0, ri_base = 0;
    logic [DW-1:0] exp_img [DEPTH];
    bit exp_ovr;

    typedef struct {
        logic          vld;
        logic [DW-1:0] dat;
        logic          e_rdy, e_oe;
        logic [DW-1:0] e_bus;
        logic          e_mi, e_ri, e_rclk, e_busy, e_ovr;
    } vec_t;
    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input bit keep_high);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        if (!keep_high) start = 1'b0;
        mi_base = mi_cnt;
        ri_base = ri_cnt;
    endtask

    task automatic send_byte(input logic [DW-1:0] b);
        chk("rx_ready_at_send", lif.rx_ready, 1);
        lif.rx_valid = 1'b1;
        lif.rx_data  = b;
        tick();
        lif.rx_valid = 1'b0;
        lif.rx_data  = DW'($urandom);
    endtask

    // The loader is busy for exactly 6 cycles after each accepted byte; gaps >= 6 keep it in step.
    task automatic run_bytes(input int first, input int gmin, input int gmax,
                             input bit junk_en, input bit start_poke, input bit seq);
        for (int i = first; i < DEPTH; i++) begin
            logic [DW-1:0] b;
            int gap, jpos;
            b = seq ? DW'(8'hA0 + i) : DW'($urandom);
            exp_img[i] = b;
            send_byte(b);
            gap  = $urandom_range(gmax, gmin);
            jpos = -1;
            if (junk_en && $urandom_range(1, 0) == 1) begin
                jpos = $urandom_range(5, 0);
                exp_ovr = 1'b1;
            end
            for (int j = 0; j < gap; j++) begin
                if (j == jpos) begin
                    lif.rx_valid = 1'b1;
                    lif.rx_data  = ~b;
                end
                if (start_poke && i == 8) start = (j == 1);
                tick();
                lif.rx_valid = 1'b0;
            end
        end
    endtask

    task automatic check_load(input string tag);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
        chk({tag, "_bus_oe"}, lif.bus_oe, 0);
        chk({tag, "_rx_ready"}, lif.rx_ready, 0);
        chk({tag, "_byte_count"}, byte_count, DEPTH);
        chk({tag, "_overrun"}, overrun, exp_ovr);
        chk({tag, "_mi_pulses"}, mi_cnt - mi_base, DEPTH);
        chk({tag, "_ri_pulses"}, ri_cnt - ri_base, DEPTH);
        for (int i = 0; i < DEPTH; i++)
            chk($sformatf("%s_ram%0d", tag, i), ram[i], exp_img[i]);
    endtask

    initial begin
        int n;
        lif.rx_valid = 1'b0;
        lif.rx_data  = '0;

        // {vld, dat, rdy, oe, bus, mi, ri, ram_clk, busy, overrun}: byte 0x5C to addr 0, junk in A_PULSE
        tbl[0] = '{1'b1, 8'h5C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 8'hEE, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_bus_oe", lif.bus_oe, 0);
        chk("rst_rx_ready", lif.rx_ready, 0);
        chk("rst_byte_count", byte_count, 0);
        rst_n = 1'b1;
        tick();

        // Load A: 0xA0..0xAF spaced 10 clk, start held high throughout
        do_start(1'b1);
        chk("A_busy_after_start", busy, 1);
        chk("A_cpu_hold_after_start", cpu_hold, 1);
        exp_ovr = 1'b0;
        run_bytes(0, 10, 10, 1'b0, 1'b0, 1'b1);
        check_load("A");
        repeat (4) tick();
        chk("held_start_no_restart_done", done, 1);
        chk("held_start_no_restart_busy", busy, 0);
        start = 1'b0;

        // Load B: table for the first byte, then random gaps, junk bytes and a start edge mid-load
        do_start(1'b0);
        chk("B_overrun_cleared", overrun, 0);
        chk("B_done_cleared", done, 0);
        chk("B_byte_count_cleared", byte_count, 0);
        for (int r = 0; r < 8; r++) begin
            lif.rx_valid = tbl[r].vld;
            lif.rx_data  = tbl[r].dat;
            chk($sformatf("tbl%0d_rx_ready", r), lif.rx_ready, tbl[r].e_rdy);
            chk($sformatf("tbl%0d_bus_oe", r), lif.bus_oe, tbl[r].e_oe);
            chk($sformatf("tbl%0d_bus_out", r), lif.bus_out, tbl[r].e_bus);
            chk($sformatf("tbl%0d_MI", r), lif.MI, tbl[r].e_mi);
            chk($sformatf("tbl%0d_RI", r), lif.RI, tbl[r].e_ri);
            chk($sformatf("tbl%0d_ram_clk", r), lif.ram_clk, tbl[r].e_rclk);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
            chk($sformatf("tbl%0d_overrun", r), overrun, tbl[r].e_ovr);
            tick();
            lif.rx_valid = 1'b0;
        end
        chk("B_byte_count_1", byte_count, 1);
        exp_img[0] = 8'h5C;
        exp_ovr = 1'b1;
        run_bytes(1, 6, 20, 1'b1, 1'b1, 1'b0);
        check_load("B");

        // Load C: back-to-back, byte offered the first cycle rx_ready returns
        do_start(1'b0);
        exp_ovr = 1'b0;
        run_bytes(0, 6, 6, 1'b0, 1'b0, 1'b0);
        check_load("C");

        // Timeout: 3 bytes then silence
        do_start(1'b0);
        for (int i = 0; i < 3; i++) begin
            send_byte(DW'($urandom));
            if (i < 2) repeat (10) tick();
        end
        n = 0;
        while (!err && n < 300) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, 6 + TO);
        chk("timeout_err", err, 1);
        chk("timeout_cpu_hold", cpu_hold, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_done", done, 0);
        chk("timeout_bus_oe", lif.bus_oe, 0);
        chk("timeout_byte_count", byte_count, 3);

        // Load D: new start edge from ERROR restarts at address 0
        do_start(1'b0);
        chk("D_err_cleared", err, 0);
        exp_ovr = 1'b0;
        run_bytes(0, 6, 30, 1'b0, 1'b0, 1'b0);
        check_load("D");

        // Reset asserted during D_PULSE
        do_start(1'b0);
        send_byte(8'h3C);
        repeat (4) tick();
        chk("dpulse_ram_clk", lif.ram_clk, 1);
        chk("dpulse_RI", lif.RI, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ram_clk", lif.ram_clk, 0);
        chk("rst_mid_RI", lif.RI, 0);
        chk("rst_mid_bus_oe", lif.bus_oe, 0);
        chk("rst_mid_cpu_hold", cpu_hold, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_err", err, 0);
        chk("post_rst_rx_ready", lif.rx_ready, 0);
        chk("post_rst_byte_count", byte_count, 0);

        chk("mi_ri_exclusive", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
